// File: rtl/audio_pkg.sv
// Shared constants and types for the audio level-metering slice.
package audio_pkg;

    localparam int unsigned SAMPLE_W = 16;

    localparam int unsigned METER_T1 = 4096;
    localparam int unsigned METER_T2 = 8192;
    localparam int unsigned METER_T3 = 16384;
    localparam int unsigned METER_T4 = 24576;

    localparam logic [3:0] METER_0 = 4'b0000;
    localparam logic [3:0] METER_1 = 4'b0001;
    localparam logic [3:0] METER_2 = 4'b0011;
    localparam logic [3:0] METER_3 = 4'b0111;
    localparam logic [3:0] METER_4 = 4'b1111;

    typedef enum logic {PK_HOLD, PK_DECAY} peak_state_t;

    function automatic logic [3:0] meter_code(input int unsigned level);
        if (level < METER_T1)      return METER_0;
        else if (level < METER_T2) return METER_1;
        else if (level < METER_T3) return METER_2;
        else if (level < METER_T4) return METER_3;
        else                       return METER_4;
    endfunction

endpackage

// File: rtl/audio_abs.sv
// Two's-complement to unsigned magnitude; the most negative input maps to 2**(W-1).
module audio_abs #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] value,
    output logic [W-1:0] mag
);

    assign mag = value[W-1] ? ((~value) + W'(1)) : value;

endmodule

// File: rtl/audio_peak_meter.sv
// Stereo-to-mono mix, peak-hold/decay envelope, LED thermometer meter and held clip flag.
module audio_peak_meter #(
    parameter int unsigned SAMPLE_W     = audio_pkg::SAMPLE_W,
    parameter int unsigned HOLD_SAMPLES = 4800,
    parameter int unsigned DECAY_STEP   = 64,
    parameter int unsigned CLIP_LEVEL   = 32000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] audio_l,
    input  logic [SAMPLE_W-1:0] audio_r,
    output logic [SAMPLE_W-1:0] audio_m,
    output logic                mono_valid,
    output logic [SAMPLE_W-1:0] peak,
    output logic [3:0]          meter,
    output logic                clip,
    output logic                meter_valid
);
    import audio_pkg::*;

    localparam int unsigned CNT_W = $clog2(HOLD_SAMPLES + 1);
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [SAMPLE_W-1:0] STEP   = SAMPLE_W'(DECAY_STEP);

    logic [SAMPLE_W-1:0] abs_l, abs_r, abs_l_q, abs_r_q, mag;
    logic signed [SAMPLE_W:0] mix_sum;

    audio_abs #(.W(SAMPLE_W)) u_abs_l (.value(audio_l), .mag(abs_l));
    audio_abs #(.W(SAMPLE_W)) u_abs_r (.value(audio_r), .mag(abs_r));
    audio_abs #(.W(SAMPLE_W)) u_abs_m (.value(audio_m), .mag(mag));

    // One extra bit of headroom so the sum never overflows before halving.
    assign mix_sum = $signed({audio_l[SAMPLE_W-1], audio_l}) + $signed({audio_r[SAMPLE_W-1], audio_r});

    always_ff @(posedge clk) begin
        if (rst) begin
            audio_m    <= '0;
            mono_valid <= 1'b0;
            abs_l_q    <= '0;
            abs_r_q    <= '0;
        end else begin
            mono_valid <= sample_valid;
            if (sample_valid) begin
                audio_m <= SAMPLE_W'(mix_sum >>> 1);
                abs_l_q <= abs_l;
                abs_r_q <= abs_r;
            end
        end
    end

    peak_state_t         state_q, state_d;
    logic [CNT_W-1:0]    hold_cnt_q, hold_cnt_d, clip_cnt_q, clip_cnt_d;
    logic [SAMPLE_W-1:0] peak_d, decayed;
    logic [3:0]          meter_d;
    logic                clip_d;

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        peak_d     = peak;
        decayed    = '0;
        clip_d     = clip;
        clip_cnt_d = clip_cnt_q;
        meter_d    = meter;
        if (mono_valid) begin
            if (mag >= peak) begin
                peak_d     = mag;
                hold_cnt_d = HOLD_INIT;
                state_d    = PK_HOLD;
            end else begin
                case (state_q)
                    PK_HOLD: begin
                        if (hold_cnt_q <= CNT_ONE) begin
                            hold_cnt_d = '0;
                            state_d    = PK_DECAY;
                        end else begin
                            hold_cnt_d = hold_cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        // Saturating step; a step wider than the sample range floors at zero.
                        if (32'(peak) > DECAY_STEP) decayed = peak - STEP;
                        peak_d = (mag > decayed) ? mag : decayed;
                    end
                endcase
            end
            meter_d = meter_code(32'(peak_d));

            if (32'(abs_l_q) >= CLIP_LEVEL || 32'(abs_r_q) >= CLIP_LEVEL) begin
                clip_d     = 1'b1;
                clip_cnt_d = HOLD_INIT;
            end else if (clip_cnt_q != '0) begin
                clip_cnt_d = clip_cnt_q - CNT_ONE;
                clip_d     = (clip_cnt_d != '0);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PK_DECAY;
            hold_cnt_q  <= '0;
            clip_cnt_q  <= '0;
            peak        <= '0;
            meter       <= '0;
            clip        <= 1'b0;
            meter_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            clip_cnt_q  <= clip_cnt_d;
            peak        <= peak_d;
            meter       <= meter_d;
            clip        <= clip_d;
            meter_valid <= mono_valid;
        end
    end

endmodule
